// File: rtl/pipe_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_pkg
// Shared pipeline definitions used by the pipeline skid register.
//   - State encoding of the two-slot skid register (value doubles as occupancy).
//   - Bit positions of the control flags and ALU opcode inside the packed
//     control word carried alongside each datapath entry.
// -----------------------------------------------------------------------------
package pipe_skid_reg_pkg;

    // Two-slot holding state; the encoding equals the number of held entries.
    typedef logic [1:0] skid_state_t;

    localparam skid_state_t ST_EMPTY = 2'b00;
    localparam skid_state_t ST_BUSY  = 2'b01;
    localparam skid_state_t ST_FULL  = 2'b10;

    // Control word layout: 7 single-bit flags followed by a 3-bit ALU opcode.
    localparam int unsigned CTRL_REGDST   = 0;
    localparam int unsigned CTRL_ALUSRC   = 1;
    localparam int unsigned CTRL_MEMTOREG = 2;
    localparam int unsigned CTRL_MEMREAD  = 3;
    localparam int unsigned CTRL_MEMWRITE = 4;
    localparam int unsigned CTRL_BRANCH   = 5;
    localparam int unsigned CTRL_REGWRITE = 6;
    localparam int unsigned CTRL_ALUOP_LO = 7;
    localparam int unsigned CTRL_ALUOP_HI = 9;
    localparam int unsigned CTRL_WIDTH    = 10;

endpackage

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Two-entry pipeline skid register between pipeline stages. Decouples the
// upstream ready from the downstream ready: in_ready depends only on the state
// register, so there is no combinational path from out_ready to in_ready.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset (highest priority)
//   flush      in   squash all held entries and any same-cycle input
//   in_valid   in   upstream entry present
//   in_ready   out  an entry can be accepted this cycle
//   in_data    in   upstream datapath payload  [DATA_W]
//   in_ctrl    in   upstream control payload   [CTRL_W]
//   out_valid  out  head entry present
//   out_ready  in   downstream accepts this cycle
//   out_data   out  head-entry datapath payload
//   out_ctrl   out  head-entry control payload, zero when out_valid is low
//   occ        out  number of held entries (0, 1 or 2)
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 138,
    parameter int unsigned CTRL_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occ
);

    skid_state_t       r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    skid_state_t       w_state_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;

    logic              w_in_fire;
    logic              w_out_fire;

    assign in_ready   = (r_state != ST_FULL);
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    assign out_data   = r_main_data;
    // A bubble must never carry live write/branch flags downstream.
    assign out_ctrl   = out_valid ? r_main_ctrl : '0;
    assign occ        = r_state;

    always_comb begin
        w_state_nxt     = r_state;
        w_main_data_nxt = r_main_data;
        w_main_ctrl_nxt = r_main_ctrl;
        w_skid_data_nxt = r_skid_data;
        w_skid_ctrl_nxt = r_skid_ctrl;

        if (flush) begin
            // Data registers may keep stale values; clearing ctrl is enough
            // because nothing is valid afterwards.
            w_state_nxt     = ST_EMPTY;
            w_main_ctrl_nxt = '0;
            w_skid_ctrl_nxt = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_data_nxt = in_data;
                        w_main_ctrl_nxt = in_ctrl;
                        w_state_nxt     = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    case ({w_in_fire, w_out_fire})
                        2'b11: begin
                            w_main_data_nxt = in_data;
                            w_main_ctrl_nxt = in_ctrl;
                        end
                        2'b10: begin
                            // Downstream stalled: park the new entry behind main.
                            w_skid_data_nxt = in_data;
                            w_skid_ctrl_nxt = in_ctrl;
                            w_state_nxt     = ST_FULL;
                        end
                        2'b01: begin
                            w_state_nxt     = ST_EMPTY;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (w_out_fire) begin
                        w_main_data_nxt = r_skid_data;
                        w_main_ctrl_nxt = r_skid_ctrl;
                        w_state_nxt     = ST_BUSY;
                    end
                end
                default: begin
                    w_state_nxt     = ST_EMPTY;
                    w_main_ctrl_nxt = '0;
                    w_skid_ctrl_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_data_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Self-checking bench for pipe_skid_reg. Accepted inputs are pushed onto a
// scoreboard queue; the queue head and size give the expected outputs each
// cycle, and an entry is popped when the output handshake completes.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int unsigned DW = 138;
    localparam int unsigned CW = 10;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } entry_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occ;

    entry_t sb_q[$];
    int     n_checks;
    int     n_pass;

    pipe_skid_reg #(
        .DATA_W (DW),
        .CTRL_W (CW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Compare DUT outputs against the scoreboard, then apply one clock cycle of
    // stimulus and advance the scoreboard by the handshakes that occur.
    task automatic step(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                        input logic ordy, input logic fl, input logic rs);
        int     m_occ;
        logic   in_fire;
        logic   out_fire;
        entry_t e;

        in_valid  = iv;
        in_data   = id;
        in_ctrl   = ic;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;

        m_occ = sb_q.size();
        check_eq("occ", 160'(occ), 160'(m_occ));
        check_eq("in_ready", 160'(in_ready), 160'(m_occ != 2));
        check_eq("out_valid", 160'(out_valid), 160'(m_occ != 0));
        if (m_occ != 0) begin
            check_eq("out_data", 160'(out_data), 160'(sb_q[0].data));
            check_eq("out_ctrl", 160'(out_ctrl), 160'(sb_q[0].ctrl));
        end else begin
            check_eq("bubble_ctrl", 160'(out_ctrl), 160'(0));
        end

        in_fire  = iv && (m_occ != 2);
        out_fire = ordy && (m_occ != 0);
        if (rs || fl) begin
            sb_q.delete();
        end else begin
            if (out_fire) void'(sb_q.pop_front());
            if (in_fire) begin
                e.data = id;
                e.ctrl = ic;
                sb_q.push_back(e);
            end
        end

        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check_eq("rst_occ", 160'(occ), 160'(0));
        check_eq("rst_in_ready", 160'(in_ready), 160'(1));
        check_eq("rst_out_valid", 160'(out_valid), 160'(0));

        // Streaming with downstream always ready: one entry per cycle, occ stays 1.
        step(1'b1, DW'(1), CW'(10'h041), 1'b1, 1'b0, 1'b0);
        step(1'b1, DW'(2), CW'(10'h042), 1'b1, 1'b0, 1'b0);
        step(1'b1, DW'(3), CW'(10'h043), 1'b1, 1'b0, 1'b0);
        check_eq("stream_occ", 160'(occ), 160'(1));
        check_eq("stream_data3", 160'(out_data), 160'(3));
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure: fill both slots, a third offer must wait.
        step(1'b1, DW'('hA), CW'(10'h0AA), 1'b0, 1'b0, 1'b0);
        step(1'b1, DW'('hB), CW'(10'h0BB), 1'b0, 1'b0, 1'b0);
        check_eq("full_occ", 160'(occ), 160'(2));
        check_eq("full_in_ready", 160'(in_ready), 160'(0));
        step(1'b1, DW'('hC), CW'(10'h0CC), 1'b0, 1'b0, 1'b0);
        check_eq("full_head", 160'(out_data), 160'('hA));
        step(1'b1, DW'('hC), CW'(10'h0CC), 1'b1, 1'b0, 1'b0);
        check_eq("drain_b", 160'(out_data), 160'('hB));
        step(1'b1, DW'('hC), CW'(10'h0CC), 1'b1, 1'b0, 1'b0);
        check_eq("drain_c", 160'(out_data), 160'('hC));
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Flush from FULL with an entry offered in the same cycle.
        step(1'b1, DW'('h11), CW'(10'h3FF), 1'b0, 1'b0, 1'b0);
        step(1'b1, DW'('h12), CW'(10'h3FF), 1'b0, 1'b0, 1'b0);
        step(1'b1, DW'('h13), CW'(10'h3FF), 1'b0, 1'b1, 1'b0);
        check_eq("flush_occ", 160'(occ), 160'(0));
        check_eq("flush_out_valid", 160'(out_valid), 160'(0));
        check_eq("flush_ctrl", 160'(out_ctrl), 160'(0));
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Reset held two cycles from FULL.
        step(1'b1, DW'('h21), CW'(10'h3FF), 1'b0, 1'b0, 1'b0);
        step(1'b1, DW'('h22), CW'(10'h3FF), 1'b0, 1'b0, 1'b0);
        step(1'b1, DW'('h23), CW'(10'h3FF), 1'b0, 1'b1, 1'b1);
        check_eq("rst2_occ_a", 160'(occ), 160'(0));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("rst2_occ", 160'(occ), 160'(0));
        check_eq("rst2_out_valid", 160'(out_valid), 160'(0));
        check_eq("rst2_in_ready", 160'(in_ready), 160'(1));
        check_eq("rst2_ctrl", 160'(out_ctrl), 160'(0));

        // Reset mid-BUSY drops the entry; accept resumes the following cycle.
        step(1'b1, DW'('h31), CW'(10'h155), 1'b0, 1'b0, 1'b0);
        step(1'b1, DW'('h32), CW'(10'h155), 1'b0, 1'b0, 1'b1);
        step(1'b1, DW'('h33), CW'(10'h2AA), 1'b0, 1'b0, 1'b0);
        check_eq("post_rst_data", 160'(out_data), 160'('h33));
        check_eq("post_rst_occ", 160'(occ), 160'(1));
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), rand_data(), CW'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0), 1'b0);
        end

        // Drain whatever remains.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        end
        check_eq("final_occ", 160'(occ), 160'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: DATA_W, default 138, packed datapath payload width (Fetch, Jump, A, B, RD, RT).
REQ-002 Parameter: CTRL_W, default 10, packed control payload width (7 flags + 3-bit ALUOP).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update on posedge clk only.
REQ-004 Port: clk  in  1  clock.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: flush  in  1  discard all held entries (branch/jump squash).
REQ-007 Port: in_valid  in  1  upstream entry present.
REQ-008 Port: in_ready  out  1  block can accept an entry this cycle.
REQ-009 Port: in_data  in  DATA_W  upstream datapath payload.
REQ-010 Port: in_ctrl  in  CTRL_W  upstream control payload.
REQ-011 Port: out_valid  out  1  output entry present.
REQ-012 Port: out_ready  in  1  downstream accepts this cycle.
REQ-013 Port: out_data  out  DATA_W  head-entry datapath payload.
REQ-014 Port: out_ctrl  out  CTRL_W  head-entry control; all-zero when out_valid=0.
REQ-015 Port: occ  out  2  entries held: 0, 1 or 2.

Function
REQ-016 Two storage slots SHALL exist: main (drives outputs) and skid; transfers occur only on valid&&ready at a clock edge.
REQ-017 States SHALL be EMPTY (occ=0), BUSY (occ=1, main full), FULL (occ=2, main+skid full).
REQ-018 in_ready SHALL be (state != FULL), a function of the state register only, with no combinational path from out_ready.
REQ-019 out_valid SHALL be (state != EMPTY); out_data/out_ctrl SHALL come directly from main registers.
REQ-020 EMPTY: in accepted -> main<=in, BUSY; otherwise remain.
REQ-021 BUSY: in and out accepted -> main<=in, stay BUSY; only in accepted -> skid<=in, FULL; only out accepted -> EMPTY.
REQ-022 FULL: out accepted -> main<=skid, BUSY; input ignored since in_ready=0.
REQ-023 Latency SHALL be 1 cycle from accepted input to out_valid when EMPTY; throughput 1 entry/cycle when out_ready held high.
REQ-024 Order SHALL be strictly FIFO; no entry is dropped or duplicated except by flush/rst.
REQ-025 flush SHALL take priority over all transfers: next state EMPTY, main and skid ctrl cleared to 0, any same-cycle input discarded; data registers MAY retain values.
REQ-026 out_ctrl SHALL be gated to zero whenever out_valid=0, so a bubble never asserts RegWrite/MemWrite/MemRead/Branch.
REQ-027 in_valid=0 with out_ready=1 in BUSY SHALL drain to EMPTY (bubble inserted); out_ready=0 SHALL hold main unchanged indefinitely.

Reset
REQ-028 rst SHALL take priority over flush; next state EMPTY, occ=0, out_valid=0, in_ready=1, main/skid data and ctrl all zero.
REQ-029 rst asserted mid-operation (any state) SHALL discard both slots in one cycle; first accept permitted the cycle after rst deasserts.

Structure
REQ-030 State encoding constants (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10) and ctrl bit-index constants (RegDst..RegWrite, ALUOP[2:0]) SHALL reside in the shared pipeline package.
REQ-031 Single module, no sub-module; occ SHALL equal the state encoding value.

Verification
REQ-032 rst held 2 cycles from FULL -> occ=0, out_valid=0, in_ready=1, out_ctrl=0 next edge.
REQ-033 out_ready=1, stream in_data=1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later, occ=1 throughout, in_ready never low.
REQ-034 out_ready=0, send 0xA,0xB -> occ=2, in_ready=0; 0xC offered is not accepted; raise out_ready -> outputs 0xA then 0xB then 0xC.
REQ-035 FULL with in_ctrl=10'h3FF held, assert flush with in_valid=1 -> next cycle occ=0, out_valid=0, out_ctrl=0; offered entry absent downstream.
REQ-036 Random in_valid/out_ready for 10k cycles -> scoreboard order/content match, no transfer while in_ready=0, out_ctrl=0 whenever out_valid=0.
